// File: rtl/upower_fetch_queue.sv
// rtl/upower_fetch_queue.sv - uPOWER instruction fetch front end with PC/instruction queue
// Owns the PC, issues word reads to a 1-cycle synchronous imem and queues {pc, instr} toward decode.
module upower_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [63:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  input  logic                   halt,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [31:0]            id_instr,
  output logic [63:0]            id_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW:0]   FULL   = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT1   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR1   = PW'(1);
  localparam logic [PW+1:0] LIMIT  = (PW+2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          req_q;
  logic [63:0]   req_pc_q;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [63:0]   pc_mem_q    [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [PW+1:0] occupancy;
  logic [1:0]    unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirects flush work but never move the FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (halt) state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // The in-flight word is counted against capacity; a same-cycle pop is not credited.
  assign occupancy = {1'b0, count_q} + (PW+2)'(req_q);

  always_comb begin
    issue = 1'b0;
    if (state_q == S_FETCH && !halt && !redirect_valid && occupancy < LIMIT) begin
      issue = 1'b1;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  assign push = req_q && !redirect_valid;
  assign pop  = id_valid && id_ready && !redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[63:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) pc_d = pc_q + 64'd4;
      if (push)  wr_ptr_d = wr_ptr_q + PTR1;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT1;
        2'b01:   count_d = count_q - CNT1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= issue;
      req_pc_q <= pc_q;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q] : 64'h0;
  assign q_count  = count_q;

  // The issue rule leaves a slot for every in-flight word, so a full-queue push is a design bug.
  assert property (@(posedge clk) disable iff (!reset) !(push && count_q == FULL));

endmodule

// File: tb/tb_upower_fetch_queue.sv
// tb/tb_upower_fetch_queue.sv - randomized self-checking bench for upower_fetch_queue
module tb_upower_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [2:0]  q_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 boot, 1 fetching, 2 halted; queue of PCs awaiting decode.
  int          m_mode;
  logic [63:0] m_pc;
  bit          m_inf;
  logic [63:0] m_inf_addr;
  logic [63:0] m_q[$];

  logic        e_req;
  logic [63:0] e_addr;
  logic        e_valid;
  logic [63:0] e_pc;
  logic [31:0] e_instr;
  logic [2:0]  e_count;
  logic [63:0] next_pc;

  always #5 clk = ~clk;

  upower_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .q_count(q_count)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h7C00_0000 + a[33:2];
  endfunction

  task automatic model_expect();
    e_req   = (m_mode == 1) && !halt && !redirect_valid && ((m_q.size() + int'(m_inf)) < DEPTH);
    e_addr  = m_pc;
    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0] : 64'h0;
    e_instr = e_valid ? mem_word(m_q[0]) : 32'h0;
    e_count = 3'(m_q.size());
  endtask

  task automatic drive(input logic rst, input logic rv, input logic [63:0] rp,
                       input logic h, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rp; halt = h; id_ready = rdy;
    #1;
  endtask

  task automatic tick();
    logic        cap_req;
    logic [63:0] cap_addr;
    cap_req  = imem_req;
    cap_addr = imem_addr;
    model_expect();
    if (!reset) begin
      m_mode = 0; m_pc = 64'h0; m_inf = 1'b0; m_q.delete();
    end else begin
      if (redirect_valid) begin
        m_q.delete(); m_inf = 1'b0; m_pc = {redirect_pc[63:2], 2'b00};
      end else begin
        if (e_valid && id_ready) void'(m_q.pop_front());
        if (m_inf) m_q.push_back(m_inf_addr);
        m_inf = e_req; m_inf_addr = m_pc;
        if (e_req) m_pc = m_pc + 64'd4;
      end
      case (m_mode)
        0: m_mode = 1;
        1: if (halt) m_mode = 2;
        2: if (!halt) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
    @(posedge clk); #1;
    imem_rdata = cap_req ? mem_word(cap_addr) : $urandom();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || id_valid !== 1'b0 || id_instr !== 32'h0 ||
        id_pc !== 64'h0 || q_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_outputs got req=%0b addr=%h valid=%0b instr=%h pc=%h cnt=%0d exp all 0",
               imem_req, imem_addr, id_valid, id_instr, id_pc, q_count);
    end
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_no_issue got req=%0b exp 0", imem_req); end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL first_issue got req=%0b addr=%h exp 1/0", imem_req, imem_addr);
    end
    tick();
    n_vec++;
    if (id_valid !== 1'b0) begin n_err++; $display("FAIL cycle2_valid got %0b exp 0", id_valid); end
    tick();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instr !== 32'h7C00_0000) begin
      n_err++; $display("FAIL cycle3_head got v=%0b pc=%h instr=%h exp 1/0/7c000000", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_stream();
    next_pc = 64'h0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== next_pc || id_instr !== (32'h7C00_0000 + 32'(k))) begin
        n_err++; $display("FAIL stream_%0d got v=%0b pc=%h instr=%h exp pc=%h", k, id_valid, id_pc, id_instr, next_pc);
      end
      next_pc = next_pc + 64'd4;
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      model_expect();
      n_vec++;
      if (imem_req !== e_req) begin n_err++; $display("FAIL stall_req_%0d got %0b exp %0b", k, imem_req, e_req); end
      tick();
    end
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (q_count !== 3'd4 || imem_req !== 1'b0 || id_pc !== next_pc) begin
      n_err++; $display("FAIL stall_full got cnt=%0d req=%0b pc=%h exp 4/0/%h", q_count, imem_req, id_pc, next_pc);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== next_pc) begin
        n_err++; $display("FAIL drain_%0d got v=%0b pc=%h exp 1/%h", k, id_valid, id_pc, next_pc);
      end
      next_pc = next_pc + 64'd4;
      tick();
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      if (m_q.size() == 3 && m_inf) begin found = 1'b1; break; end
      tick();
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL redir_setup got no 3+1 state exp found"); end
    drive(1'b1, 1'b1, 64'h40, 1'b0, 1'b0);
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_no_issue got %0b exp 0", imem_req); end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_addr !== 64'h40 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL redir_t1 got v=%0b cnt=%0d addr=%h req=%0b exp 0/0/40/1", id_valid, q_count, imem_addr, imem_req);
    end
    tick();
    n_vec++;
    if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_t2 got v=%0b exp 0", id_valid); end
    tick();
    next_pc = 64'h40;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== next_pc || id_instr !== mem_word(next_pc)) begin
        n_err++; $display("FAIL redir_seq_%0d got v=%0b pc=%h instr=%h exp pc=%h", k, id_valid, id_pc, id_instr, next_pc);
      end
      next_pc = next_pc + 64'd4;
      tick();
    end
  endtask

  task automatic test_redirect_pop();
    drive(1'b1, 1'b1, 64'h43, 1'b0, 1'b1);
    n_vec++;
    if (id_valid !== 1'b1) begin n_err++; $display("FAIL rpop_pre got v=%0b exp 1", id_valid); end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_addr !== 64'h40) begin
      n_err++; $display("FAIL rpop_t1 got cnt=%0d v=%0b addr=%h exp 0/0/40", q_count, id_valid, imem_addr);
    end
    tick(); tick();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 64'h40) begin
      n_err++; $display("FAIL rpop_t3 got v=%0b pc=%h exp 1/40", id_valid, id_pc);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b1, 64'h18, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    tick(); tick();
    drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h20 || q_count !== 3'd1) begin
      n_err++; $display("FAIL halt_enter got req=%0b addr=%h cnt=%0d exp 0/20/1", imem_req, imem_addr, q_count);
    end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    n_vec++;
    if (q_count !== 3'd2 || imem_req !== 1'b0) begin
      n_err++; $display("FAIL halt_inflight got cnt=%0d req=%0b exp 2/0", q_count, imem_req);
    end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
    n_vec++;
    if (id_pc !== 64'h18) begin n_err++; $display("FAIL halt_pop0 got %h exp 18", id_pc); end
    tick();
    n_vec++;
    if (id_pc !== 64'h1C) begin n_err++; $display("FAIL halt_pop1 got %h exp 1c", id_pc); end
    tick();
    n_vec++;
    if (q_count !== 3'd0 || id_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h20) begin
      n_err++; $display("FAIL halt_empty got cnt=%0d v=%0b req=%0b addr=%h exp 0/0/0/20", q_count, id_valid, imem_req, imem_addr);
    end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL unhalt_t0 got req=%0b exp 0", imem_req); end
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h20) begin
      n_err++; $display("FAIL unhalt_t1 got req=%0b addr=%h exp 1/20", imem_req, imem_addr);
    end
    tick(); tick();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 64'h20) begin
      n_err++; $display("FAIL unhalt_head got v=%0b pc=%h exp 1/20", id_valid, id_pc);
    end
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || id_valid !== 1'b0 || id_pc !== 64'h0 || q_count !== 3'd0) begin
      n_err++; $display("FAIL midreset got req=%0b addr=%h v=%0b pc=%h cnt=%0d exp all 0", imem_req, imem_addr, id_valid, id_pc, q_count);
    end
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    n_vec++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_boot got req=%0b exp 0", imem_req); end
    tick();
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL rst_issue got req=%0b addr=%h exp 1/0", imem_req, imem_addr);
    end
    tick(); tick();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 64'h0) begin
      n_err++; $display("FAIL rst_head got v=%0b pc=%h exp 1/0", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    tick(); tick();
    next_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== next_pc || id_instr !== mem_word(next_pc)) begin
        n_err++; $display("FAIL wrap_%0d got v=%0b pc=%h instr=%h exp pc=%h", k, id_valid, id_pc, id_instr, next_pc);
      end
      next_pc = next_pc + 64'd4;
      tick();
    end
  endtask

  task automatic test_random();
    logic h = 1'b0;
    logic [63:0] rp;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      rp = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 24'hFFFFFF, 8'($urandom_range(0, 255))}
                                       : {$urandom(), $urandom()};
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) == 0), rp, h,
            ($urandom_range(0, 3) != 0));
      model_expect();
      n_vec++;
      if (imem_req !== e_req) begin n_err++; $display("FAIL rnd_req c=%0d got %0b exp %0b", c, imem_req, e_req); end
      n_vec++;
      if (imem_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, e_addr); end
      n_vec++;
      if (id_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, id_valid, e_valid); end
      n_vec++;
      if (id_pc !== e_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got %h exp %h", c, id_pc, e_pc); end
      n_vec++;
      if (id_instr !== e_instr) begin n_err++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, id_instr, e_instr); end
      n_vec++;
      if (q_count !== e_count) begin n_err++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, q_count, e_count); end
      tick();
    end
  endtask

  initial begin
    imem_rdata = 32'h0; reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    halt = 1'b0; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_halt();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
